par_domain_receiver: RTL and testbench

- Receiving end of the two-domain labelled word channel (domain L=0, domain H=1) used between security-partitioned producers and consumers.
- Accepts domain-tagged words into per-domain FIFOs and drains them on a fixed, data-independent L/H time-slot schedule.
- Domain H occupancy and activity must never influence L-domain-visible timing or data (non-interference).
- Every port and register carries a label: L, or dependent Par(domain select).

---
 rtl/par_chan_pkg.sv | 24 ++
 rtl/par_fifo_bank.sv | 73 +++++++
 rtl/par_domain_receiver.sv | 90 +++++++++
 tb/tb_par_domain_receiver.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/par_chan_pkg.sv
// Shared definitions for the two-domain labelled word channel.
// Provides the domain tag type, default payload width and FIFO depth,
// and a constant clog2 helper used to size pointers and counters.
package par_chan_pkg;

  typedef enum logic {
    DOM_L = 1'b0,
    DOM_H = 1'b1
  } dom_t;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_DEPTH  = 4;

  // Ceiling log2; clog2(1) = 0. Used at elaboration time only.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/par_fifo_bank.sv
// Single-domain synchronous FIFO: registered pointers and count, no
// write-to-read bypass, and no push into a full bank even with a same-cycle pop.
// Ports: clk, reset (sync, active-low), i_push/i_pop requests, i_data,
//        o_full, o_empty, o_count (0..DEPTH), o_head (0 when empty).
// Every register here carries the label of the domain the instance serves.
module par_fifo_bank
  import par_chan_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = clog2(DEF_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [CNT_W-1:0]  o_count,
  output logic [DATA_W-1:0] o_head
);

  localparam int PTR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

  // Fullness is judged on the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not cleared by reset; a push coincident with reset is dropped.
  always_ff @(posedge clk) begin
    if (reset && w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

endmodule

// File: rtl/par_domain_receiver.sv
// Receiving end of the L/H labelled word channel: per-domain FIFOs drained on
// a fixed alternating slot schedule that never looks at either domain's state.
// Ports: clk, reset (sync, active-low) [L]; in_valid/in_data [Par(in_dom)],
//        in_dom [L], in_ready [Par(in_dom)]; out_slot [L]; out_valid/out_data,
//        out_ready [Par(out_slot)]; l_count [L]; h_count [H].
module par_domain_receiver
  import par_chan_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = clog2(DEF_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_dom,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_slot,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  l_count,
  output logic [CNT_W-1:0]  h_count
);

  // Slot register [L]: toggles unconditionally, so drain timing is fixed.
  dom_t r_slot;

  // Per-domain control. The L-bank wires are gated only by in_dom, r_slot
  // and L-labelled data; nothing from the H bank feeds them.
  logic              w_push_l, w_pop_l;   // [L]
  logic              w_push_h, w_pop_h;   // [H]
  logic              w_full_l, w_empty_l; // [L]
  logic              w_full_h, w_empty_h; // [H]
  logic [DATA_W-1:0] w_head_l;            // [L]
  logic [DATA_W-1:0] w_head_h;            // [H]

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_slot <= DOM_L;
    end else begin
      r_slot <= (r_slot == DOM_L) ? DOM_H : DOM_L;
    end
  end

  assign w_push_l = in_valid && (in_dom == DOM_L) && !w_full_l;
  assign w_push_h = in_valid && (in_dom == DOM_H) && !w_full_h;
  assign w_pop_l  = (r_slot == DOM_L) && !w_empty_l && out_ready;
  assign w_pop_h  = (r_slot == DOM_H) && !w_empty_h && out_ready;

  par_fifo_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_bank_l (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push_l),
    .i_pop   (w_pop_l),
    .i_data  (in_data),
    .o_full  (w_full_l),
    .o_empty (w_empty_l),
    .o_count (l_count),
    .o_head  (w_head_l)
  );

  par_fifo_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_bank_h (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push_h),
    .i_pop   (w_pop_h),
    .i_data  (in_data),
    .o_full  (w_full_h),
    .o_empty (w_empty_h),
    .o_count (h_count),
    .o_head  (w_head_h)
  );

  // Muxes selected by L-labelled signals: results carry Par(select) labels.
  assign in_ready  = (in_dom == DOM_H) ? !w_full_h : !w_full_l;
  assign out_slot  = r_slot;
  assign out_valid = (r_slot == DOM_H) ? !w_empty_h : !w_empty_l;
  assign out_data  = (r_slot == DOM_H) ? w_head_h : w_head_l;

endmodule

// File: tb/tb_par_domain_receiver.sv
module tb_par_domain_receiver;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;
  localparam int NI_N   = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_dom = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              out_slot;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready = 1'b0;
  logic [CNT_W-1:0]  l_count;
  logic [CNT_W-1:0]  h_count;

  int n_checks = 0;
  int n_errors = 0;

  par_domain_receiver #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_dom    (in_dom),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_slot  (out_slot),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .l_count   (l_count),
    .h_count   (h_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: two queues and a slot bit ----------
  logic [DATA_W-1:0] q_l[$];
  logic [DATA_W-1:0] q_h[$];
  bit m_slot = 0;
  bit m_live = 0;

  always @(posedge clk) begin
    bit pop_l, pop_h, push_l, push_h;
    if (!reset) begin
      q_l.delete();
      q_h.delete();
      m_slot = 0;
      m_live = 1;
    end else if (m_live) begin
      pop_l  = (m_slot == 0) && (q_l.size() > 0) && out_ready;
      pop_h  = (m_slot == 1) && (q_h.size() > 0) && out_ready;
      push_l = in_valid && !in_dom && (q_l.size() < DEPTH);
      push_h = in_valid && in_dom && (q_h.size() < DEPTH);
      if (pop_l) void'(q_l.pop_front());
      if (pop_h) void'(q_h.pop_front());
      if (push_l) q_l.push_back(in_data);
      if (push_h) q_h.push_back(in_data);
      m_slot = !m_slot;
    end
  end

  // ---------------- per-cycle compare against the model -----------------
  always @(negedge clk) begin
    int sz, szi, dat;
    if (m_live) begin
      sz  = m_slot ? q_h.size() : q_l.size();
      szi = in_dom ? q_h.size() : q_l.size();
      dat = (sz == 0) ? 0 : (m_slot ? int'(q_h[0]) : int'(q_l[0]));
      chk("out_slot", out_slot, m_slot);
      chk("out_valid", out_valid, sz != 0);
      chk("out_data", out_data, dat);
      chk("in_ready", in_ready, szi < DEPTH);
      chk("l_count", l_count, q_l.size());
      chk("h_count", h_count, q_h.size());
      chk("l_count_bound", l_count <= DEPTH, 1);
      chk("h_count_bound", h_count <= DEPTH, 1);
    end
  end

  // ---------------- stimulus helpers -------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_slot(input bit v);
    for (int k = 0; k < 3 && out_slot !== v; k++) tick();
    chk("wait_slot", out_slot, v);
  endtask

  task automatic push(input bit dom, input logic [DATA_W-1:0] d);
    in_dom = dom;
    in_valid = 1'b1;
    in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  // L-side stimulus replayed in both non-interference runs
  bit                l_dom [NI_N];
  bit                l_val [NI_N];
  logic [DATA_W-1:0] l_dat [NI_N];
  bit                l_rdy [NI_N];
  int                tr    [2][NI_N];

  task automatic run_ni(input int run);
    do_reset();
    for (int i = 0; i < NI_N; i++) begin
      in_dom = l_dom[i];
      if (!l_dom[i]) begin
        in_valid = l_val[i];
        in_data  = l_dat[i];
      end else begin
        in_valid = (run == 1);
        in_data  = DATA_W'($urandom);
      end
      out_ready = (i % 2 == 0) ? l_rdy[i] : ((run == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
      #1;
      tr[run][i] = {20'd0,
                    (!in_dom) ? in_ready : 1'b0,
                    out_slot,
                    (!out_slot) ? out_valid : 1'b0,
                    (!out_slot) ? out_data : 4'd0,
                    3'd0, l_count};
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  logic [DATA_W-1:0] exp_h [4];
  int got;
  int max_l;

  initial begin
    exp_h[0] = 4'h9; exp_h[1] = 4'hA; exp_h[2] = 4'hB; exp_h[3] = 4'hC;

    // Reset, then idle: slot alternates, everything empty.
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("idle_slot", out_slot, i % 2);
      chk("idle_valid", out_valid, 0);
      chk("idle_data", out_data, 0);
      chk("idle_ready", in_ready, 1);
      chk("idle_counts", {l_count, h_count}, 0);
      tick();
    end

    // Single L word, presented in the following L slot, then popped.
    wait_slot(1);
    push(0, 4'h3);
    chk("l3_slot", out_slot, 0);
    chk("l3_valid", out_valid, 1);
    chk("l3_data", out_data, 3);
    chk("l3_count", l_count, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("l3_popped", l_count, 0);

    // Fill H, confirm per-domain in_ready, refuse a 5th word, drain in order.
    for (int i = 0; i < 4; i++) push(1, exp_h[i]);
    chk("h_full_count", h_count, 4);
    in_dom = 1'b1;
    #1;
    chk("h_full_rdy", in_ready, 0);
    in_dom = 1'b0;
    #1;
    chk("l_rdy_while_h_full", in_ready, 1);
    push(1, 4'hD);
    chk("h_5th_held", h_count, 4);
    got = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && got < 4; k++) begin
      if (out_slot == 1'b1 && out_valid) begin
        chk("h_drain_data", out_data, exp_h[got]);
        got++;
      end
      if (out_slot == 1'b0) chk("h_drain_l_quiet", out_valid, 0);
      tick();
    end
    out_ready = 1'b0;
    chk("h_drain_done", got, 4);
    chk("h_drain_empty", h_count, 0);

    // Wrap-around: 10 L words one at a time.
    max_l = 0;
    for (int k = 0; k < 10; k++) begin
      wait_slot(1);
      push(0, DATA_W'(k));
      chk("wrap_valid", out_valid, 1);
      chk("wrap_data", out_data, k);
      if (l_count > max_l) max_l = l_count;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("wrap_count0", l_count, 0);
    end
    chk("wrap_max_count", max_l, 1);

    // L full: a push alongside a pop is refused, accepted the next cycle.
    for (int i = 1; i <= 4; i++) push(0, DATA_W'(i));
    chk("lfull_count", l_count, 4);
    wait_slot(0);
    in_dom = 1'b0;
    in_valid = 1'b1;
    in_data = 4'h5;
    out_ready = 1'b1;
    #1;
    chk("lfull_rdy", in_ready, 0);
    tick();
    chk("lfull_after_pop", l_count, 3);
    out_ready = 1'b0;
    #1;
    chk("lfull_rdy_back", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("lfull_accept", l_count, 4);

    // Reset mid-stream discards both domains.
    do_reset();
    push(0, 4'h1);
    push(0, 4'h2);
    push(1, 4'h7);
    push(1, 4'h8);
    push(1, 4'h9);
    chk("mid_l", l_count, 2);
    chk("mid_h", h_count, 3);
    do_reset();
    chk("mid_rst_l", l_count, 0);
    chk("mid_rst_h", h_count, 0);
    chk("mid_rst_slot", out_slot, 0);
    chk("mid_rst_valid", out_valid, 0);

    // Non-interference: same L stimulus, H idle vs H saturating.
    for (int i = 0; i < NI_N; i++) begin
      l_dom[i] = 1'($urandom_range(0, 1));
      l_val[i] = 1'($urandom_range(0, 1));
      l_dat[i] = DATA_W'($urandom);
      l_rdy[i] = ($urandom_range(0, 3) == 0);
    end
    run_ni(0);
    run_ni(1);
    for (int i = 0; i < NI_N; i++) chk("noninterference", tr[1][i], tr[0][i]);

    // Random stress with occasional resets; the model compare covers it.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_dom    = 1'($urandom_range(0, 1));
      in_data   = DATA_W'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      reset     = ($urandom_range(0, 60) != 0);
      tick();
    end
    reset = 1'b1;
    in_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
